// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - interval codes, default durations and timer state encoding
package traffic_pkg;

  localparam logic [1:0] INT_BASE = 2'b00;
  localparam logic [1:0] INT_EXT  = 2'b01;
  localparam logic [1:0] INT_YEL  = 2'b10;

  localparam int DEF_T_BASE = 6;
  localparam int DEF_T_EXT  = 3;
  localparam int DEF_T_YEL  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/interval_timer_if.sv
// rtl/interval_timer_if.sv - FSM <-> interval timer request/program bus
// INTERVAL_TIMER_REMAIN_EN adds the remaining-seconds signal.
interface interval_timer_if #(
  parameter int VAL_W = 4
);
  logic             start_timer;
  logic [1:0]       requesting_interval;
  logic             reprogram;
  logic [1:0]       prog_sel;
  logic [VAL_W-1:0] prog_value;
  logic             expired;
  logic             busy;
`ifdef INTERVAL_TIMER_REMAIN_EN
  logic [VAL_W-1:0] remaining;
`endif

  modport master (
    output start_timer, requesting_interval, reprogram, prog_sel, prog_value,
    input  expired, busy
`ifdef INTERVAL_TIMER_REMAIN_EN
    , input remaining
`endif
  );

  modport slave (
    input  start_timer, requesting_interval, reprogram, prog_sel, prog_value,
    output expired, busy
`ifdef INTERVAL_TIMER_REMAIN_EN
    , output remaining
`endif
  );
endinterface

// File: rtl/sec_tick_gen.sv
// rtl/sec_tick_gen.sv - clock divider producing a 1-cycle tick every CLK_PER_SEC cycles
module sec_tick_gen #(
  parameter int CLK_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic tick
);
  localparam int DIV_W = $clog2(CLK_PER_SEC);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_PER_SEC - 1);

  logic [DIV_W-1:0] div;

  // Held at zero while idle so every interval starts from a fresh second.
  always_ff @(posedge clk) begin
    if (!resetn || clear || !run) begin
      div <= '0;
    end else if (div == LAST) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  assign tick = run && (div == LAST);
endmodule

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - programmable interval timer with duration register file
// INTERVAL_TIMER_REMAIN_EN exposes the live seconds count as remaining.
module interval_timer
  import traffic_pkg::*;
#(
  parameter int CLK_PER_SEC = 50_000_000,
  parameter int VAL_W       = 4,
  parameter int T_BASE_DEF  = DEF_T_BASE,
  parameter int T_EXT_DEF   = DEF_T_EXT,
  parameter int T_YEL_DEF   = DEF_T_YEL
) (
  input  logic             clk,
  input  logic             reset,
  interval_timer_if.slave  tif
);
  logic [VAL_W-1:0] t_base, t_ext, t_yel;
  logic [VAL_W-1:0] sel_val;
  logic [VAL_W-1:0] count, count_next;
  logic             expired_q, expired_next;
  logic             tick;
  state_t           state, state_next;

  sec_tick_gen #(.CLK_PER_SEC(CLK_PER_SEC)) u_tick (
    .clk    (clk),
    .resetn (reset),
    .clear  (tif.start_timer),
    .run    (state == RUN),
    .tick   (tick)
  );

  // Reprogramming only touches the stored durations, never a running count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      t_base <= VAL_W'(T_BASE_DEF);
      t_ext  <= VAL_W'(T_EXT_DEF);
      t_yel  <= VAL_W'(T_YEL_DEF);
    end else if (tif.reprogram) begin
      case (tif.prog_sel)
        INT_BASE: t_base <= tif.prog_value;
        INT_EXT:  t_ext  <= tif.prog_value;
        INT_YEL:  t_yel  <= tif.prog_value;
        default:  ;
      endcase
    end
  end

  always_comb begin
    case (tif.requesting_interval)
      INT_EXT: sel_val = t_ext;
      INT_YEL: sel_val = t_yel;
      default: sel_val = t_base;
    endcase
  end

  // A start outranks the final tick, so a restart never emits expired.
  always_comb begin
    state_next   = state;
    count_next   = count;
    expired_next = 1'b0;
    if (tif.start_timer) begin
      state_next = RUN;
      count_next = (sel_val == '0) ? VAL_W'(1) : sel_val;
    end else if (state == RUN && tick) begin
      if (count > VAL_W'(1)) begin
        count_next = count - VAL_W'(1);
      end else begin
        count_next   = '0;
        state_next   = IDLE;
        expired_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      expired_q <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      expired_q <= expired_next;
    end
  end

  assign tif.expired = expired_q;
  assign tif.busy    = (state == RUN);
`ifdef INTERVAL_TIMER_REMAIN_EN
  assign tif.remaining = count;
`endif
endmodule

// File: tb/tb_interval_timer.sv
// tb/tb_interval_timer.sv - directed and random checks of interval_timer against a deadline model
module tb_interval_timer;
  localparam int CPS   = 4;
  localparam int VAL_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  interval_timer_if #(.VAL_W(VAL_W)) tif ();

  interval_timer #(
    .CLK_PER_SEC(CPS), .VAL_W(VAL_W),
    .T_BASE_DEF(6), .T_EXT_DEF(3), .T_YEL_DEF(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .tif   (tif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: each interval is an absolute deadline edge number.
  int     t_reg[3];
  longint cyc = 0;
  longint deadline = 0;
  bit     active = 0;
  bit     exp_pulse = 0;

  longint start_cyc = 0;
  longint last_exp = -1;
  int     n_pulse = 0;

  task automatic check(input string tag, input longint got, input longint want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, cyc, got, want);
    end
  endtask

  function automatic int idx(input logic [1:0] code);
    return (code == 2'b11) ? 0 : int'(code);
  endfunction

  task automatic step(input logic st, input logic [1:0] ri, input logic rp,
                      input logic [1:0] ps, input logic [VAL_W-1:0] pv, input logic rs);
    int n;
    tif.start_timer         = st;
    tif.requesting_interval = ri;
    tif.reprogram           = rp;
    tif.prog_sel            = ps;
    tif.prog_value          = pv;
    reset                   = rs;
    @(posedge clk);
    cyc++;
    exp_pulse = 0;
    if (!rs) begin
      t_reg[0] = 6; t_reg[1] = 3; t_reg[2] = 2;
      active = 0;
    end else begin
      if (st) begin
        n = t_reg[idx(ri)];
        if (n == 0) n = 1;
        deadline = cyc + longint'(n) * CPS;
        active = 1;
        start_cyc = cyc;
      end else if (active && cyc == deadline) begin
        exp_pulse = 1;
        active = 0;
      end
      if (rp && ps != 2'b11) t_reg[ps] = int'(pv);
    end
    #1;
    check("expired", longint'(tif.expired), longint'(exp_pulse));
    check("busy", longint'(tif.busy), longint'(active));
`ifdef INTERVAL_TIMER_REMAIN_EN
    check("remaining", longint'(tif.remaining),
          active ? (deadline - cyc + CPS - 1) / CPS : 0);
`endif
    if (tif.expired === 1'b1) begin
      n_pulse++;
      last_exp = cyc;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 2'b00, 0, 2'b00, '0, 1);
  endtask

  initial begin
    t_reg[0] = 6; t_reg[1] = 3; t_reg[2] = 2;
    for (int i = 0; i < 3; i++) step(0, 2'b00, 0, 2'b00, '0, 0);
    idle(2);

    // 1: default t_base = 6 s -> 24 cycles
    n_pulse = 0;
    step(1, 2'b00, 0, 2'b00, '0, 1);
    idle(30);
    check("t1_latency", last_exp - start_cyc, 24);
    check("t1_pulses", n_pulse, 1);

    // 2: t_yel = 5 s -> 20 cycles
    step(0, 2'b00, 1, 2'b10, 4'd5, 1);
    n_pulse = 0;
    step(1, 2'b10, 0, 2'b00, '0, 1);
    idle(25);
    check("t2_latency", last_exp - start_cyc, 20);
    check("t2_pulses", n_pulse, 1);

    // 3: restart discards the first interval
    n_pulse = 0;
    step(1, 2'b00, 0, 2'b00, '0, 1);
    idle(9);
    step(1, 2'b10, 0, 2'b00, '0, 1);
    idle(30);
    check("t3_latency", last_exp - start_cyc, 20);
    check("t3_pulses", n_pulse, 1);

    // 3b: t_yel back to 2 s -> restart expires at +8
    step(0, 2'b00, 1, 2'b10, 4'd2, 1);
    n_pulse = 0;
    step(1, 2'b00, 0, 2'b00, '0, 1);
    idle(9);
    step(1, 2'b10, 0, 2'b00, '0, 1);
    idle(30);
    check("t3b_latency", last_exp - start_cyc, 8);
    check("t3b_pulses", n_pulse, 1);

    // 4: zero duration loads as 1 s
    step(0, 2'b00, 1, 2'b01, 4'd0, 1);
    n_pulse = 0;
    step(1, 2'b01, 0, 2'b00, '0, 1);
    idle(8);
    check("t4_latency", last_exp - start_cyc, 4);

    // 4b: start in the same cycle as reprogram uses the old value
    n_pulse = 0;
    step(1, 2'b01, 1, 2'b01, 4'd7, 1);
    idle(10);
    check("t4b_latency", last_exp - start_cyc, 4);

    // 5: reset mid-run kills the interval and restores defaults
    step(0, 2'b00, 1, 2'b00, 4'd9, 1);
    n_pulse = 0;
    step(1, 2'b00, 0, 2'b00, '0, 1);
    idle(4);
    step(0, 2'b00, 0, 2'b00, '0, 0);
    idle(40);
    check("t5_pulses", n_pulse, 0);
    step(1, 2'b00, 0, 2'b00, '0, 1);
    idle(30);
    check("t5_latency", last_exp - start_cyc, 24);

    // random traffic against the deadline model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 29) == 0), 2'($urandom), ($urandom_range(0, 7) == 0),
           2'($urandom), VAL_W'($urandom), ($urandom_range(0, 299) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
